reg_feeder: RTL and testbench



---
 rtl/reg_feed_pkg.sv | 15 +
 rtl/reg_feeder_if.sv | 13 +
 rtl/reg_feed_fifo.sv | 55 +++++
 rtl/reg_feeder.sv | 120 ++++++++++++
 tb/tb_reg_feeder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_feed_pkg.sv
// rtl/reg_feed_pkg.sv - shared state enum and default sizing for the register feeder
package reg_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } feed_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_GAP_W = 4;
    localparam int WR_CNT_W  = 16;

endpackage

// File: rtl/reg_feeder_if.sv
// rtl/reg_feeder_if.sv - upstream valid/ready word stream into the register feeder
interface reg_feeder_if
    import reg_feed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/reg_feed_fifo.sv
// rtl/reg_feed_fifo.sv - power-of-two synchronous FIFO with synchronous clear
module reg_feed_fifo
    import reg_feed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/reg_feeder.sv
// rtl/reg_feeder.sv - turns buffered words into spaced single-cycle register write pulses; REG_FEED_CNT_EN adds wr_count
module reg_feeder
    import reg_feed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    reg_feeder_if.slave            in_if,
    input  logic [GAP_W-1:0]       gap,
    output logic                   enable,
    output logic [WIDTH-1:0]       data,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef REG_FEED_CNT_EN
    ,
    output logic [WR_CNT_W-1:0]    wr_count
`endif
);
    feed_state_e      state_q, state_d;
    logic             enable_q, enable_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic             push, pop, full, empty;
    logic [WIDTH-1:0] head;

    assign in_if.in_ready = !full && !flush;
    assign push           = in_if.in_valid && in_if.in_ready;
    assign enable         = enable_q;
    assign data           = data_q;

    reg_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_if.in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        data_d   = data_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        data_d   = head;
                        enable_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (gap != '0) begin
                        cnt_d   = gap - GAP_W'(1);
                        state_d = GAP;
                    end else if (!empty) begin
                        pop      = 1'b1;
                        data_d   = head;
                        enable_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - GAP_W'(1);
                    end else if (!empty) begin
                        pop      = 1'b1;
                        data_d   = head;
                        enable_d = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef REG_FEED_CNT_EN
    logic [WR_CNT_W-1:0] wr_cnt_q;

    // Counts pulses actually presented to the register; flush never clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         wr_cnt_q <= '0;
        else if (enable_q) wr_cnt_q <= wr_cnt_q + WR_CNT_W'(1);
    end

    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_reg_feeder.sv
// tb/tb_reg_feeder.sv - directed-vector bench for reg_feeder
module tb_reg_feeder;
    import reg_feed_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] gap = 4'd0;
    logic       enable;
    logic [7:0] data;
    logic [2:0] fifo_count;
`ifdef REG_FEED_CNT_EN
    logic [15:0] wr_count;
`endif

    reg_feeder_if #(.WIDTH(8)) in_if ();

    reg_feeder #(.WIDTH(8), .DEPTH(4), .GAP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_if      (in_if.slave),
        .gap        (gap),
        .enable     (enable),
        .data       (data),
        .fifo_count (fifo_count)
`ifdef REG_FEED_CNT_EN
        ,
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulse_t[$];
    logic [7:0] pulse_d[$];
    int hold_err = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            last_data = data;
        end else if (enable) begin
            pulse_t.push_back(cyc);
            pulse_d.push_back(data);
            last_data = data;
        end else begin
            if (data !== last_data) hold_err++;
            last_data = data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        int n = 0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = w;
        while (!in_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(n), 32'd0);
        tick();
        in_if.in_valid = 1'b0;
    endtask

    task automatic clear_log();
        pulse_t.delete();
        pulse_d.delete();
        hold_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_log();
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;
        tick();
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(in_if.in_ready), 32'd1);
`ifdef REG_FEED_CNT_EN
        check("rst_wr_count", 32'(wr_count), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // latency: push at edge N, pulse in cycle after N+1
        gap = 4'd0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'hA5;
        tick();
        in_if.in_valid = 1'b0;
        check("lat_n_enable", 32'(enable), 32'd0);
        check("lat_n_count", 32'(fifo_count), 32'd1);
        tick();
        check("lat_n1_enable", 32'(enable), 32'd1);
        check("lat_n1_data", 32'(data), 32'hA5);
        tick();
        check("lat_after_enable", 32'(enable), 32'd0);
        check("lat_after_data", 32'(data), 32'hA5);

        // asynchronous reset mid-stream
        push_word(8'h11);
        push_word(8'h22);
        check("mid_enable_hi", 32'(enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_enable", 32'(enable), 32'd0);
        check("async_data", 32'(data), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        check("post_rst_enable", 32'(enable), 32'd0);

        // back-to-back with gap 0
        gap = 4'd0;
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        repeat (6) tick();
        check("b2b_pulses", 32'(pulse_t.size()), 32'd4);
        if (pulse_t.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("b2b_data%0d", i), 32'(pulse_d[i]), 32'(i + 1));
            check("b2b_span", 32'(pulse_t[3] - pulse_t[0]), 32'd3);
        end

        // gap of 3: pulses 4 cycles apart, data held in between
        clear_log();
        gap = 4'd3;
        push_word(8'h3A);
        push_word(8'h3B);
        push_word(8'h3C);
        repeat (16) tick();
        check("gap_pulses", 32'(pulse_t.size()), 32'd3);
        if (pulse_t.size() == 3) begin
            check("gap_sp0", 32'(pulse_t[1] - pulse_t[0]), 32'd4);
            check("gap_sp1", 32'(pulse_t[2] - pulse_t[1]), 32'd4);
            check("gap_d2", 32'(pulse_d[2]), 32'h3C);
        end
        check("gap_hold", 32'(hold_err), 32'd0);

        // full / backpressure with gap 15
        clear_log();
        gap = 4'd15;
        for (int i = 0; i < 5; i++) push_word(8'hB0 + 8'(i));
        check("bp_full_count", 32'(fifo_count), 32'd4);
        check("bp_ready_low", 32'(in_if.in_ready), 32'd0);
        push_word(8'hB5);
        repeat (90) tick();
        check("bp_pulses", 32'(pulse_t.size()), 32'd6);
        if (pulse_t.size() == 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("bp_order%0d", i), 32'(pulse_d[i]), 32'hB0 + 32'(i));
            check("bp_spacing", 32'(pulse_t[5] - pulse_t[4]), 32'd16);
        end
        check("bp_hold", 32'(hold_err), 32'd0);
        check("bp_drained", 32'(fifo_count), 32'd0);

        // flush with three buffered words
        clear_log();
        gap = 4'd15;
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
        check("fl_pre_count", 32'(fifo_count), 32'd3);
        flush = 1'b1;
        #1;
        check("fl_ready", 32'(in_if.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("fl_count", 32'(fifo_count), 32'd0);
        check("fl_enable", 32'(enable), 32'd0);
        repeat (40) tick();
        check("fl_pulses", 32'(pulse_t.size()), 32'd1);
        check("fl_data_hold", 32'(data), 32'hC0);

`ifdef REG_FEED_CNT_EN
        do_reset();
        gap = 4'd0;
        for (int i = 0; i < 5; i++) push_word(8'(i));
        repeat (4) tick();
        check("cnt_five", 32'(wr_count), 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush", 32'(wr_count), 32'd5);
        for (int i = 0; i < 65531; i++) push_word(8'(i));
        repeat (4) tick();
        check("cnt_wrap", 32'(wr_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
